// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: trap/mret sequencer driving the CSR file's interrupt-side write port and fetch redirect
// Ports: clk/rst (async active-high); int_flag_i, inst_i, inst_addr_i, jump_flag_i, jump_addr_i are event inputs;
// global_int_en_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i come from the CSR file;
// hold_flag_o stalls the pipeline, we_o/waddr_o/data_o form the CSR write port,
// int_assert_o/int_addr_o pulse a one-cycle fetch redirect.
module csr_trap_ctrl #(
  parameter logic [31:0] CAUSE_ECALL  = 32'd11,
  parameter logic [31:0] CAUSE_EBREAK = 32'd3,
  parameter logic [31:0] CAUSE_INT    = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  int_flag_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_addr_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        global_int_en_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic [31:0] csr_mstatus_i,
  output logic        hold_flag_o,
  output logic        we_o,
  output logic [31:0] waddr_o,
  output logic [31:0] data_o,
  output logic        int_assert_o,
  output logic [31:0] int_addr_o
);
  typedef enum logic [2:0] {IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, W_MRET, ASSERT} state_t;
  state_t state;
  logic [31:0] cause, epc;
  logic mret_seq;
  logic is_ecall, is_ebreak, is_mret, sync_ev, int_ev;
  logic [31:0] ms;
  assign is_ecall  = inst_i == 32'h0000_0073;
  assign is_ebreak = inst_i == 32'h0010_0073;
  assign is_mret   = inst_i == 32'h3020_0073;
  assign sync_ev   = is_ecall | is_ebreak;
  assign int_ev    = (|int_flag_i) & global_int_en_i;
  assign ms        = csr_mstatus_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cause    <= '0;
      epc      <= '0;
      mret_seq <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (sync_ev) begin
            state    <= W_MEPC;
            cause    <= is_ecall ? CAUSE_ECALL : CAUSE_EBREAK;
            epc      <= inst_addr_i;
            mret_seq <= 1'b0;
          end else if (is_mret) begin
            state    <= W_MRET;
            mret_seq <= 1'b1;
          end else if (int_ev) begin
            state    <= W_MEPC;
            cause    <= CAUSE_INT;
            epc      <= jump_flag_i ? jump_addr_i : inst_addr_i;
            mret_seq <= 1'b0;
          end
        end
        W_MEPC:    state <= W_MSTATUS;
        W_MSTATUS: state <= W_MCAUSE;
        W_MCAUSE:  state <= ASSERT;
        W_MRET:    state <= ASSERT;
        default:   state <= IDLE;
      endcase
    end
  end
  // hold is the only output reacting combinationally to events; gated by rst so reset clears it at once
  always_comb begin
    hold_flag_o  = !rst && (state != IDLE || sync_ev || is_mret || int_ev);
    we_o         = state == W_MEPC || state == W_MSTATUS || state == W_MCAUSE || state == W_MRET;
    waddr_o      = state == W_MEPC ? 32'h341 :
                   state == W_MCAUSE ? 32'h342 :
                   (state == W_MSTATUS || state == W_MRET) ? 32'h300 : 32'h0;
    data_o       = state == W_MEPC ? epc :
                   state == W_MCAUSE ? cause :
                   state == W_MSTATUS ? {ms[31:8], ms[3], ms[6:4], 1'b0, ms[2:0]} :
                   state == W_MRET ? {ms[31:8], 1'b1, ms[6:4], ms[7], ms[2:0]} : 32'h0;
    int_assert_o = state == ASSERT;
    int_addr_o   = state != ASSERT ? 32'h0 : mret_seq ? csr_mepc_i : csr_mtvec_i;
  end
endmodule

// File: tb/tb_csr_trap_ctrl.sv
module tb_csr_trap_ctrl;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] MRET   = 32'h3020_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst;
  logic [7:0] int_flag_i;
  logic [31:0] inst_i, inst_addr_i, jump_addr_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
  logic jump_flag_i, global_int_en_i;
  logic hold_flag_o, we_o, int_assert_o;
  logic [31:0] waddr_o, data_o, int_addr_o;
  int n_chk = 0;
  int n_err = 0;

  csr_trap_ctrl dut (
    .clk(clk), .rst(rst), .int_flag_i(int_flag_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i), .global_int_en_i(global_int_en_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i), .csr_mstatus_i(csr_mstatus_i),
    .hold_flag_o(hold_flag_o), .we_o(we_o), .waddr_o(waddr_o), .data_o(data_o),
    .int_assert_o(int_assert_o), .int_addr_o(int_addr_o)
  );

  always #5 clk = ~clk;

  function automatic logic [98:0] outs();
    return {hold_flag_o, we_o, waddr_o, data_o, int_assert_o, int_addr_o};
  endfunction

  function automatic logic [98:0] pk(input logic [31:0] h, w, a, d, s, ad);
    return {h[0], w[0], a, d, s[0], ad};
  endfunction

  task automatic test_reset();
    inst_i = ECALL; int_flag_i = 8'hff; global_int_en_i = 1'b1;
    #2;
    n_chk++;
    if (outs() !== pk(0,0,0,0,0,0)) begin n_err++; $display("FAIL reset_outputs got %h exp %h", outs(), pk(0,0,0,0,0,0)); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; inst_i = NOP; int_flag_i = 8'h0;
    #2;
    n_chk++;
    if (outs() !== pk(0,0,0,0,0,0)) begin n_err++; $display("FAIL reset_idle got %h exp %h", outs(), pk(0,0,0,0,0,0)); end
    @(posedge clk); #1;
  endtask

  task automatic test_ecall();
    logic [98:0] e[6];
    e = '{pk(1,0,0,0,0,0), pk(1,1,'h341,'h100,0,0), pk(1,1,'h300,'h80,0,0),
          pk(1,1,'h342,11,0,0), pk(1,0,0,0,1,'h200), pk(0,0,0,0,0,0)};
    inst_i = ECALL; inst_addr_i = 'h100; csr_mstatus_i = 'h8; csr_mtvec_i = 'h200;
    for (int i = 0; i < 6; i++) begin
      #2;
      n_chk++;
      if (outs() !== e[i]) begin n_err++; $display("FAIL ecall step %0d got %h exp %h", i, outs(), e[i]); end
      @(posedge clk); #1;
      if (i == 0) inst_i = NOP;
    end
  endtask

  task automatic test_int_jump();
    logic [98:0] e[6];
    e = '{pk(1,0,0,0,0,0), pk(1,1,'h341,'h340,0,0), pk(1,1,'h300,'h80,0,0),
          pk(1,1,'h342,32'h8000_0004,0,0), pk(1,0,0,0,1,'h200), pk(0,0,0,0,0,0)};
    inst_i = NOP; inst_addr_i = 'h180; int_flag_i = 8'h01; global_int_en_i = 1'b1;
    jump_flag_i = 1'b1; jump_addr_i = 'h340; csr_mstatus_i = 'h8; csr_mtvec_i = 'h200;
    for (int i = 0; i < 6; i++) begin
      #2;
      n_chk++;
      if (outs() !== e[i]) begin n_err++; $display("FAIL int_jump step %0d got %h exp %h", i, outs(), e[i]); end
      @(posedge clk); #1;
      if (i == 0) begin int_flag_i = 8'h0; jump_flag_i = 1'b0; end
    end
  endtask

  task automatic test_masked();
    logic [98:0] e[9];
    e = '{pk(0,0,0,0,0,0), pk(0,0,0,0,0,0), pk(0,0,0,0,0,0), pk(1,0,0,0,0,0),
          pk(1,1,'h341,'h120,0,0), pk(1,1,'h300,'h80,0,0), pk(1,1,'h342,3,0,0),
          pk(1,0,0,0,1,'h200), pk(0,0,0,0,0,0)};
    inst_i = NOP; inst_addr_i = 'h120; int_flag_i = 8'h01; global_int_en_i = 1'b0;
    csr_mstatus_i = 'h8; csr_mtvec_i = 'h200;
    for (int i = 0; i < 9; i++) begin
      #2;
      n_chk++;
      if (outs() !== e[i]) begin n_err++; $display("FAIL masked step %0d got %h exp %h", i, outs(), e[i]); end
      @(posedge clk); #1;
      if (i == 2) inst_i = EBREAK;
      if (i == 3) inst_i = NOP;
    end
    int_flag_i = 8'h0;
  endtask

  task automatic test_mret();
    logic [98:0] e[4];
    e = '{pk(1,0,0,0,0,0), pk(1,1,'h300,'h88,0,0), pk(1,0,0,0,1,'h104), pk(0,0,0,0,0,0)};
    inst_i = MRET; csr_mstatus_i = 'h80; csr_mepc_i = 'h104; csr_mtvec_i = 'h200;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_chk++;
      if (outs() !== e[i]) begin n_err++; $display("FAIL mret step %0d got %h exp %h", i, outs(), e[i]); end
      @(posedge clk); #1;
      if (i == 0) inst_i = NOP;
    end
  endtask

  task automatic test_simultaneous();
    logic [98:0] e[7];
    logic [98:0] f[9];
    e = '{pk(1,0,0,0,0,0), pk(1,1,'h341,'h100,0,0), pk(1,1,'h300,'h80,0,0),
          pk(1,1,'h342,11,0,0), pk(1,0,0,0,1,'h200), pk(0,0,0,0,0,0), pk(0,0,0,0,0,0)};
    f = '{pk(1,0,0,0,0,0), pk(1,1,'h300,'h88,0,0), pk(1,0,0,0,1,'h100), pk(1,0,0,0,0,0),
          pk(1,1,'h341,'h104,0,0), pk(1,1,'h300,'h80,0,0), pk(1,1,'h342,32'h8000_0004,0,0),
          pk(1,0,0,0,1,'h200), pk(0,0,0,0,0,0)};
    inst_i = ECALL; inst_addr_i = 'h100; int_flag_i = 8'h01; global_int_en_i = 1'b1;
    jump_flag_i = 1'b0; csr_mstatus_i = 'h8; csr_mtvec_i = 'h200;
    for (int i = 0; i < 7; i++) begin
      #2;
      n_chk++;
      if (outs() !== e[i]) begin n_err++; $display("FAIL simul_trap step %0d got %h exp %h", i, outs(), e[i]); end
      @(posedge clk); #1;
      if (i == 0) inst_i = NOP;
      if (i == 2) begin global_int_en_i = 1'b0; csr_mstatus_i = 'h80; end
    end
    inst_i = MRET; csr_mepc_i = 'h100; inst_addr_i = 'h104;
    for (int i = 0; i < 9; i++) begin
      #2;
      n_chk++;
      if (outs() !== f[i]) begin n_err++; $display("FAIL simul_mret step %0d got %h exp %h", i, outs(), f[i]); end
      @(posedge clk); #1;
      if (i == 0) inst_i = NOP;
      if (i == 1) begin global_int_en_i = 1'b1; csr_mstatus_i = 'h88; end
      if (i == 3) begin int_flag_i = 8'h0; global_int_en_i = 1'b0; end
    end
  endtask

  task automatic test_back_to_back();
    logic [98:0] e[11];
    e = '{pk(1,0,0,0,0,0), pk(1,1,'h341,'h10,0,0), pk(1,1,'h300,0,0,0), pk(1,1,'h342,3,0,0),
          pk(1,0,0,0,1,'h40), pk(1,0,0,0,0,0), pk(1,1,'h341,'h10,0,0), pk(1,1,'h300,0,0,0),
          pk(1,1,'h342,3,0,0), pk(1,0,0,0,1,'h40), pk(0,0,0,0,0,0)};
    inst_i = EBREAK; inst_addr_i = 'h10; csr_mstatus_i = 'h0; csr_mtvec_i = 'h40;
    for (int i = 0; i < 11; i++) begin
      #2;
      n_chk++;
      if (outs() !== e[i]) begin n_err++; $display("FAIL back_to_back step %0d got %h exp %h", i, outs(), e[i]); end
      @(posedge clk); #1;
      if (i == 5) inst_i = NOP;
    end
  endtask

  task automatic test_reset_mid();
    inst_i = ECALL; inst_addr_i = 'h100; csr_mstatus_i = 'h8; csr_mtvec_i = 'h200;
    @(posedge clk); #1;
    inst_i = NOP;
    @(posedge clk); #1;
    #2;
    n_chk++;
    if (outs() !== pk(1,1,'h300,'h80,0,0)) begin n_err++; $display("FAIL rst_mid_pre got %h exp %h", outs(), pk(1,1,'h300,'h80,0,0)); end
    rst = 1'b1;
    #1;
    n_chk++;
    if (outs() !== pk(0,0,0,0,0,0)) begin n_err++; $display("FAIL rst_mid_async got %h exp %h", outs(), pk(0,0,0,0,0,0)); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_chk++;
      if (outs() !== pk(0,0,0,0,0,0)) begin n_err++; $display("FAIL rst_mid_after step %0d got %h exp 0", i, outs()); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [31:0] m_epc, m_cause, ms;
    logic [98:0] ex;
    logic sy, rt, it;
    int q[$];
    int k, r;
    m_epc = '0; m_cause = '0;
    for (int c = 0; c < 330; c++) begin
      if (c < 300) begin
        r = $urandom_range(0, 9);
        inst_i = r == 0 ? ECALL : r == 1 ? EBREAK : r == 2 ? MRET : $urandom;
        int_flag_i = $urandom_range(0, 1) ? 8'($urandom) : 8'h0;
        global_int_en_i = 1'($urandom);
        jump_flag_i = 1'($urandom);
        jump_addr_i = $urandom; inst_addr_i = $urandom;
        csr_mtvec_i = $urandom; csr_mepc_i = $urandom; csr_mstatus_i = $urandom;
      end else begin
        inst_i = NOP; int_flag_i = 8'h0;
      end
      #2;
      ms = csr_mstatus_i;
      sy = inst_i == ECALL || inst_i == EBREAK;
      rt = inst_i == MRET;
      it = int_flag_i != 0 && global_int_en_i;
      if (q.size() == 0) begin
        ex = pk({31'b0, sy | rt | it}, 0, 0, 0, 0, 0);
        if (sy) begin q = '{1, 2, 3, 4}; m_epc = inst_addr_i; m_cause = inst_i == ECALL ? 11 : 3; end
        else if (rt) q = '{5, 6};
        else if (it) begin q = '{1, 2, 3, 4}; m_epc = jump_flag_i ? jump_addr_i : inst_addr_i; m_cause = 32'h8000_0004; end
      end else begin
        k = q.pop_front();
        ex = k == 1 ? pk(1, 1, 'h341, m_epc, 0, 0) :
             k == 2 ? pk(1, 1, 'h300, (ms & ~32'h88) | (ms[3] ? 32'h80 : 32'h0), 0, 0) :
             k == 3 ? pk(1, 1, 'h342, m_cause, 0, 0) :
             k == 4 ? pk(1, 0, 0, 0, 1, csr_mtvec_i) :
             k == 5 ? pk(1, 1, 'h300, (ms & ~32'h08) | 32'h80 | (ms[7] ? 32'h08 : 32'h0), 0, 0) :
                      pk(1, 0, 0, 0, 1, csr_mepc_i);
      end
      n_chk++;
      if (outs() !== ex) begin n_err++; $display("FAIL random cycle %0d got %h exp %h", c, outs(), ex); end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1; int_flag_i = 8'h0; inst_i = NOP; inst_addr_i = '0; jump_flag_i = 1'b0; jump_addr_i = '0;
    global_int_en_i = 1'b0; csr_mtvec_i = '0; csr_mepc_i = '0; csr_mstatus_i = '0;
    test_reset();
    test_ecall();
    test_int_jump();
    test_masked();
    test_mret();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
